// File: rtl/random_ball_launcher.sv
// Serve-parameter generator: mixes an external count into a 16-bit Galois LFSR
// and derives a registered serve position, speed and signed launch angle from it.
module random_ball_launcher #(
  parameter int N       = 183,
  parameter int X_SERVE = 64,
  parameter int Y_BASE  = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [8:0]  cnt,
  output logic [21:0] ball_location,
  output logic [15:0] ball_velocity,
  output logic [15:0] ball_angle
);

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [8:0]  N_W       = 9'(N);
  localparam logic [10:0] X_W       = 11'(X_SERVE);
  localparam logic [10:0] Y_W       = 11'(Y_BASE);
  localparam logic [15:0] HALF_W    = 16'(N >> 1);

  logic [15:0] lfsr;

  logic [15:0]        mix;
  logic [15:0]        nxt;
  logic [7:0]         ang_idx;
  logic [7:0]         y_off;
  logic signed [15:0] ang_s;
  logic [10:0]        y_pos;
  logic [15:0]        vel;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // An 8-bit value is always below 2N for legal N, so one compare-subtract suffices.
  function automatic logic [7:0] mod_n(input logic [7:0] v);
    logic [8:0] w;
    w = {1'b0, v};
    if (w >= N_W) w = w - N_W;
    return w[7:0];
  endfunction

  always_comb begin
    mix = lfsr ^ {7'b0, cnt};
    if (mix == 16'h0000) mix = LFSR_SEED;
    nxt     = lfsr_step(mix);
    ang_idx = mod_n(nxt[7:0]);
    y_off   = mod_n(nxt[15:8]);
    ang_s   = $signed({8'b0, ang_idx}) - $signed(HALF_W);
    y_pos   = Y_W + {3'b0, y_off};
    vel     = 16'd2 + {12'b0, nxt[3:0] ^ nxt[15:12]};
  end

  // Output stage: state and all fields update together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr          <= LFSR_SEED;
      ball_location <= {X_W, Y_W + HALF_W[10:0]};
      ball_velocity <= 16'd2;
      ball_angle    <= 16'd0;
    end else if (en) begin
      lfsr          <= nxt;
      ball_location <= {X_W, y_pos};
      ball_velocity <= vel;
      ball_angle    <= ang_s;
    end
  end

endmodule

// File: tb/tb_random_ball_launcher.sv
// Directed and range-sweep checks for random_ball_launcher at default parameters.
module tb_random_ball_launcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [8:0]  cnt;
  logic [21:0] ball_location;
  logic [15:0] ball_velocity;
  logic [15:0] ball_angle;

  int errors = 0;
  int checks = 0;

  random_ball_launcher dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .cnt           (cnt),
    .ball_location (ball_location),
    .ball_velocity (ball_velocity),
    .ball_angle    (ball_angle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [8:0]  cnt;
    logic [21:0] loc;
    logic [15:0] vel;
    logic [15:0] ang;
    logic [15:0] lfsr;
  } vec_t;

  // {X=64, Y=48+91=139}
  localparam logic [21:0] RST_LOC = {11'd64, 11'd139};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [21:0] loc, input logic [15:0] vel,
                           input logic [15:0] ang, input logic [15:0] st);
    check({tag, " loc"},  32'(ball_location), 32'(loc));
    check({tag, " vel"},  32'(ball_velocity), 32'(vel));
    check({tag, " ang"},  32'(ball_angle),    32'(ang));
    check({tag, " lfsr"}, 32'(dut.lfsr),      32'(st));
  endtask

  task automatic cycle(input logic r, input logic e, input logic [8:0] c);
    rst = r; en = e; cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic range_check(input string tag);
    check({tag, " ang lo"}, 32'($signed(ball_angle) >= -91), 32'd1);
    check({tag, " ang hi"}, 32'($signed(ball_angle) <= 91), 32'd1);
    check({tag, " y rng"}, 32'(ball_location[10:0] >= 11'd48 && ball_location[10:0] <= 11'd230), 32'd1);
    check({tag, " x"}, 32'(ball_location[21:11]), 32'd64);
    check({tag, " vel rng"}, 32'(ball_velocity >= 16'd2 && ball_velocity <= 16'd17), 32'd1);
    check({tag, " lfsr nz"}, 32'(dut.lfsr != 16'h0000), 32'd1);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b1, 9'h1D5, 22'h20086, 16'h0011, 16'h003F, 16'h569A};
    vecs[1] = '{1'b1, 9'h1F5, 22'h200CF, 16'h0010, 16'hFFA5, 16'h9FB7};
    vecs[2] = '{1'b1, 9'h000, 22'h20074, 16'h0006, 16'hFFC9, 16'hFBDB};
    vecs[3] = '{1'b1, 9'h1FF, 22'h200AD, 16'h0007, 16'hFFB7, 16'h7D12};

    rst = 1'b1; en = 1'b0; cnt = 9'h0;
    cycle(1'b1, 1'b0, 9'h0);
    cycle(1'b1, 1'b1, 9'h155);
    check_all("reset", RST_LOC, 16'd2, 16'd0, 16'hACE1);

    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, vecs[i].en, vecs[i].cnt);
      check_all($sformatf("vec%0d", i), vecs[i].loc, vecs[i].vel, vecs[i].ang, vecs[i].lfsr);
    end

    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 9'($urandom));
      check_all($sformatf("hold%0d", i), vecs[3].loc, vecs[3].vel, vecs[3].ang, vecs[3].lfsr);
    end

    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 9'($urandom));
    cycle(1'b1, 1'b1, 9'($urandom));
    check_all("midrst", RST_LOC, 16'd2, 16'd0, 16'hACE1);
    cycle(1'b0, 1'b1, 9'h1D5);
    check_all("after rst", vecs[0].loc, vecs[0].vel, vecs[0].ang, vecs[0].lfsr);

    for (int i = 0; i < 10000; i++) begin
      cycle(1'b0, 1'b1, 9'($urandom));
      range_check("sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
